// File: rtl/arp_tx_framer.sv
// ARP request/reply frame generator driving a GMII transmit byte stream (preamble, headers, padding, FCS).
// Optional macro ARP_TX_GAP_EN adds an interframe-gap state after the FCS.
module arp_tx_framer #(
    parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
    parameter logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd1, 8'd10},
    parameter logic [47:0] DES_MAC   = 48'hff_ff_ff_ff_ff_ff,
    parameter logic [31:0] DES_IP    = {8'd192, 8'd168, 8'd1, 8'd102}
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        arp_tx_en,
    input  logic        arp_tx_type,
    input  logic [47:0] des_mac,
    input  logic [31:0] des_ip,
    output logic        gmii_txd_valid,
    output logic [7:0]  gmii_txd_data,
    output logic        tx_busy,
    output logic        tx_done
);

`ifdef ARP_TX_GAP_EN
    typedef enum logic [5:0] {
        IDLE     = 6'b000001,
        PREAMBLE = 6'b000010,
        ETH_HEAD = 6'b000100,
        ARP_DATA = 6'b001000,
        FCS      = 6'b010000,
        GAP      = 6'b100000
    } state_t;
    // 11 GAP cycles plus the IDLE cycle that accepts the next start give a 12-cycle gap.
    localparam logic [5:0] GAP_LAST = 6'd10;
`else
    typedef enum logic [4:0] {
        IDLE     = 5'b00001,
        PREAMBLE = 5'b00010,
        ETH_HEAD = 5'b00100,
        ARP_DATA = 5'b01000,
        FCS      = 5'b10000
    } state_t;
`endif

    localparam logic [31:0] CRC_POLY = 32'hEDB88320;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] crc_q, crc_d;
    logic        type_q, type_d;
    logic [47:0] mac_q, mac_d;
    logic [31:0] ip_q, ip_d;
    logic        done_q, done_d;

    logic        tx_valid;
    logic [7:0]  tx_byte;
    logic [111:0] eth_hdr, eth_sh;
    logic [223:0] arp_hdr, arp_sh;
    logic [31:0]  fcs_sh;

    function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        end
        return r;
    endfunction

    // Header images indexed by the byte counter, first byte in the top bits.
    always_comb begin
        eth_hdr = {(type_q ? mac_q : 48'hff_ff_ff_ff_ff_ff), BOARD_MAC, 16'h0806};
        arp_hdr = {48'h0001_0800_0604, 8'h00, (type_q ? 8'h02 : 8'h01),
                   BOARD_MAC, BOARD_IP, (type_q ? mac_q : 48'h0), ip_q};
        eth_sh  = eth_hdr << {cnt_q, 3'b000};
        arp_sh  = arp_hdr << {cnt_q, 3'b000};
        fcs_sh  = (~crc_q) >> {cnt_q[1:0], 3'b000};
    end

    always_comb begin
        tx_valid = 1'b0;
        tx_byte  = 8'h00;
        case (state_q)
            PREAMBLE: begin
                tx_valid = 1'b1;
                tx_byte  = (cnt_q == 6'd7) ? 8'hD5 : 8'h55;
            end
            ETH_HEAD: begin
                tx_valid = 1'b1;
                tx_byte  = eth_sh[111:104];
            end
            ARP_DATA: begin
                tx_valid = 1'b1;
                tx_byte  = (cnt_q < 6'd28) ? arp_sh[223:216] : 8'h00;
            end
            FCS: begin
                tx_valid = 1'b1;
                tx_byte  = fcs_sh[7:0];
            end
            default: begin
                tx_valid = 1'b0;
                tx_byte  = 8'h00;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        type_d  = type_q;
        mac_d   = mac_q;
        ip_d    = ip_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (arp_tx_en) begin
                    state_d = PREAMBLE;
                    type_d  = arp_tx_type;
                    mac_d   = (des_mac == 48'h0) ? DES_MAC : des_mac;
                    ip_d    = (des_ip == 32'h0) ? DES_IP : des_ip;
                end
            end
            PREAMBLE: if (cnt_q == 6'd7)  state_d = ETH_HEAD;
            ETH_HEAD: if (cnt_q == 6'd13) state_d = ARP_DATA;
            ARP_DATA: if (cnt_q == 6'd45) state_d = FCS;
            FCS: begin
                if (cnt_q == 6'd3) begin
                    done_d  = 1'b1;
`ifdef ARP_TX_GAP_EN
                    state_d = GAP;
`else
                    state_d = IDLE;
`endif
                end
            end
`ifdef ARP_TX_GAP_EN
            GAP: if (cnt_q == GAP_LAST) state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase

        cnt_d = ((state_d != state_q) || (state_q == IDLE)) ? 6'd0 : cnt_q + 6'd1;

        // CRC is seeded as the SFD goes out and then covers header and payload only.
        crc_d = crc_q;
        if ((state_q == PREAMBLE) && (cnt_q == 6'd7)) begin
            crc_d = 32'hFFFF_FFFF;
        end else if ((state_q == ETH_HEAD) || (state_q == ARP_DATA)) begin
            crc_d = crc_next(crc_q, tx_byte);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
            crc_q   <= 32'hFFFF_FFFF;
            type_q  <= 1'b0;
            mac_q   <= 48'h0;
            ip_q    <= 32'h0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            crc_q   <= crc_d;
            type_q  <= type_d;
            mac_q   <= mac_d;
            ip_q    <= ip_d;
            done_q  <= done_d;
        end
    end

    assign gmii_txd_valid = tx_valid;
    assign gmii_txd_data  = tx_byte;
    assign tx_busy        = (state_q != IDLE);
    assign tx_done        = done_q;

endmodule

// File: tb/tb_arp_tx_framer.sv
// Directed/randomized bench for arp_tx_framer: frames are rebuilt from the ARP/Ethernet
// field rules and compared byte-for-byte, plus FCS, residue, busy, reset and gap checks.
module tb_arp_tx_framer;

    localparam logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55;
    localparam logic [31:0] BOARD_IP  = 32'hC0A8_010A;
    localparam logic [47:0] DES_MAC   = 48'hff_ff_ff_ff_ff_ff;
    localparam logic [31:0] DES_IP    = 32'hC0A8_0166;
`ifdef ARP_TX_GAP_EN
    localparam int EXP_GAP = 12;
    localparam logic EXP_BUSY_AT_DONE = 1'b1;
`else
    localparam int EXP_GAP = 1;
    localparam logic EXP_BUSY_AT_DONE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        arp_tx_en;
    logic        arp_tx_type;
    logic [47:0] des_mac;
    logic [31:0] des_ip;
    logic        gmii_txd_valid;
    logic [7:0]  gmii_txd_data;
    logic        tx_busy;
    logic        tx_done;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] dat_q[$];

    arp_tx_framer dut (
        .clk(clk), .resetn(resetn), .arp_tx_en(arp_tx_en), .arp_tx_type(arp_tx_type),
        .des_mac(des_mac), .des_ip(des_ip), .gmii_txd_valid(gmii_txd_valid),
        .gmii_txd_data(gmii_txd_data), .tx_busy(tx_busy), .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reflected CRC-32 over q[lo..hi], register returned without final inversion.
    function automatic logic [31:0] crc_range(input logic [7:0] q[$], input int lo, input int hi);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = lo; i <= hi; i++) begin
            c = c ^ {24'h0, q[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    function automatic void push_bytes(input logic [47:0] v, input int n);
        for (int i = 0; i < n; i++) dat_q.push_back(v[8*(n-1-i) +: 8]);
    endfunction

    function automatic void build_expected(input logic typ, input logic [47:0] mac, input logic [31:0] ip);
        logic [47:0] m;
        logic [31:0] a;
        logic [31:0] fcs;
        m = (mac == 48'h0) ? DES_MAC : mac;
        a = (ip == 32'h0) ? DES_IP : ip;
        dat_q.delete();
        push_bytes(typ ? m : 48'hff_ff_ff_ff_ff_ff, 6);
        push_bytes(BOARD_MAC, 6);
        push_bytes(48'h0806, 2);
        push_bytes(48'h0001_0800_0604, 6);
        push_bytes(typ ? 48'h2 : 48'h1, 2);
        push_bytes(BOARD_MAC, 6);
        push_bytes({16'h0, BOARD_IP}, 4);
        push_bytes(typ ? m : 48'h0, 6);
        push_bytes({16'h0, a}, 4);
        for (int i = 0; i < 18; i++) dat_q.push_back(8'h00);
        fcs = ~crc_range(dat_q, 0, 59);
        exp_q.delete();
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        foreach (dat_q[i]) exp_q.push_back(dat_q[i]);
        for (int i = 0; i < 4; i++) exp_q.push_back(fcs[8*i +: 8]);
    endfunction

    task automatic run_frame(input logic typ, input logic [47:0] mac, input logic [31:0] ip,
                             input int inject_at, input int reset_at, input logic release_rst);
        int   dones;
        logic aborted;
        logic [31:0] c;
        @(negedge clk);
        arp_tx_en = 1'b1; arp_tx_type = typ; des_mac = mac; des_ip = ip;
        if (release_rst) resetn = 1'b1;
        @(negedge clk);
        arp_tx_en = 1'b0; arp_tx_type = ~typ;
        des_mac = {16'($urandom), $urandom}; des_ip = $urandom;
        check("first_byte_valid", 64'(gmii_txd_valid), 64'd1);
        check("busy_after_start", 64'(tx_busy), 64'd1);
        got_q.delete(); dones = 0; aborted = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (!gmii_txd_valid) break;
            got_q.push_back(gmii_txd_data);
            if (tx_done) dones++;
            arp_tx_en = (got_q.size() == inject_at);
            if (got_q.size() == reset_at) begin
                resetn = 1'b0;
                #1;
                check("rst_valid", 64'(gmii_txd_valid), 64'd0);
                check("rst_data", 64'(gmii_txd_data), 64'd0);
                check("rst_busy", 64'(tx_busy), 64'd0);
                check("rst_done", 64'(tx_done), 64'd0);
                aborted = 1'b1;
                break;
            end
            @(negedge clk);
        end
        arp_tx_en = 1'b0;
        if (aborted) begin
            @(negedge clk);
            check("rst_held_idle", 64'(gmii_txd_valid), 64'd0);
            return;
        end
        check("valid_len", 64'(got_q.size()), 64'd72);
        check("eof_data", 64'(gmii_txd_data), 64'd0);
        check("eof_done", 64'(tx_done), 64'd1);
        check("eof_busy", 64'(tx_busy), 64'(EXP_BUSY_AT_DONE));
        if (tx_done) dones++;
        @(negedge clk);
        if (tx_done) dones++;
        check("done_once", 64'(dones), 64'd1);
        build_expected(typ, mac, ip);
        for (int i = 0; i < 72; i++)
            check($sformatf("byte%0d", i), 64'((i < got_q.size()) ? got_q[i] : 8'hxx), 64'(exp_q[i]));
        if (got_q.size() == 72) begin
            c = ~crc_range(got_q, 8, 67);
            check("fcs_vs_data", 64'({got_q[71], got_q[70], got_q[69], got_q[68]}), 64'(c));
            check("crc_residue", 64'(crc_range(got_q, 8, 71)), 64'h0000_0000_DEBB_20E3);
        end
        for (int n = 0; n < 40 && tx_busy; n++) @(negedge clk);
        check("idle_return", 64'(tx_busy), 64'd0);
    endtask

    initial begin
        int  lead, n1, gap;
        logic        rt;
        logic [47:0] rm;
        logic [31:0] ri;
        resetn = 1'b0; arp_tx_en = 1'b0; arp_tx_type = 1'b0; des_mac = 48'h0; des_ip = 32'h0;
        repeat (3) @(negedge clk);
        check("reset_valid", 64'(gmii_txd_valid), 64'd0);
        check("reset_data", 64'(gmii_txd_data), 64'd0);
        check("reset_busy", 64'(tx_busy), 64'd0);
        check("reset_done", 64'(tx_done), 64'd0);

        // Reply with start on the first edge after reset release.
        run_frame(1'b1, 48'h00_11_22_AA_BB_CC, 32'hC0A8_0166, -1, -1, 1'b1);
        check("reply_dst_mac", 64'({got_q[8], got_q[9], got_q[10], got_q[11], got_q[12], got_q[13]}),
              64'h0000_0011_22AA_BBCC);
        check("reply_opcode", 64'({got_q[28], got_q[29]}), 64'h0002);
        check("reply_tgt_ip", 64'({got_q[46], got_q[47], got_q[48], got_q[49]}), 64'hC0A8_0166);

        // Request with zero inputs falls back to DES_MAC / DES_IP.
        run_frame(1'b0, 48'h0, 32'h0, -1, -1, 1'b0);
        check("req_dst_mac", 64'({got_q[8], got_q[9], got_q[10], got_q[11], got_q[12], got_q[13]}),
              64'h0000_FFFF_FFFF_FFFF);
        check("req_opcode", 64'({got_q[28], got_q[29]}), 64'h0001);
        check("req_tgt_mac", 64'({got_q[40], got_q[41], got_q[42], got_q[43], got_q[44], got_q[45]}), 64'h0);
        check("req_tgt_ip", 64'({got_q[46], got_q[47], got_q[48], got_q[49]}), 64'hC0A8_0166);

        // Second start while busy is ignored.
        run_frame(1'b1, 48'h02_03_04_05_06_07, 32'h0A00_0001, 30, -1, 1'b0);

        // Mid-frame reset, then a clean frame on release.
        run_frame(1'b1, 48'h0A_0B_0C_0D_0E_0F, 32'h0A00_0002, -1, 40, 1'b0);
        run_frame(1'b0, 48'h0A_0B_0C_0D_0E_0F, 32'h0A00_0003, -1, -1, 1'b1);

        for (int k = 0; k < 4; k++) begin
            rt = 1'($urandom_range(0, 1));
            rm = ($urandom_range(0, 3) == 0) ? 48'h0 : {16'($urandom), $urandom};
            ri = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            run_frame(rt, rm, ri, -1, -1, 1'b0);
        end

        // Start held high: measure the idle spacing between consecutive frames.
        @(negedge clk);
        arp_tx_en = 1'b1; arp_tx_type = 1'b1; des_mac = 48'h0; des_ip = 32'h0;
        lead = 0; n1 = 0; gap = 0;
        while (!gmii_txd_valid && lead < 10) begin @(negedge clk); lead++; end
        while (gmii_txd_valid && n1 < 100) begin @(negedge clk); n1++; end
        while (!gmii_txd_valid && gap < 40) begin @(negedge clk); gap++; end
        arp_tx_en = 1'b0;
        check("b2b_len", 64'(n1), 64'd72);
        check("b2b_gap", 64'(gap), 64'(EXP_GAP));
        for (int n = 0; n < 200 && (tx_busy || gmii_txd_valid); n++) @(negedge clk);
        check("b2b_idle_end", 64'(tx_busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/arp_tx_framer.md
ARP_TX_FRAMER -- requirements
Module: arp_tx_framer

Interface
REQ-001 Parameter BOARD_MAC, default 48'h00_11_22_33_44_55, local MAC placed in the Ethernet source and ARP sender MAC fields.
REQ-002 Parameter BOARD_IP, default 192.168.1.10, local IP placed in the ARP sender IP field.
REQ-003 Parameter DES_MAC, default 48'hff_ff_ff_ff_ff_ff, fallback target MAC used when the des_mac input is zero.
REQ-004 Parameter DES_IP, default 192.168.1.102, fallback target IP used when the des_ip input is zero.
REQ-005 clk  input  1  clock; all logic on the rising edge.
REQ-006 resetn  input  1  reset, asynchronous, active-low.
REQ-007 arp_tx_en  input  1  single-cycle start request.
REQ-008 arp_tx_type  input  1  frame type: 0 = request, 1 = reply.
REQ-009 des_mac  input  48  target MAC, typically src_mac from the ARP receiver.
REQ-010 des_ip  input  32  target IP, typically src_ip from the ARP receiver.
REQ-011 gmii_txd_valid  output  1  GMII transmit enable.
REQ-012 gmii_txd_data  output  8  GMII transmit byte.
REQ-013 tx_busy  output  1  high from the cycle after accepted start until return to IDLE.
REQ-014 tx_done  output  1  one-cycle pulse at frame completion.

Function
REQ-015 State machine states SHALL be IDLE, PREAMBLE, ETH_HEAD, ARP_DATA, FCS, plus GAP when ARP_TX_GAP_EN is defined, one-hot encoded and registered.
REQ-016 In IDLE, arp_tx_en=1 SHALL latch arp_tx_type, des_mac (or DES_MAC if zero) and des_ip (or DES_IP if zero); the first preamble byte is valid on the next cycle.
REQ-017 arp_tx_en while tx_busy=1 SHALL be ignored, with no queuing and no change to latched fields.
REQ-018 PREAMBLE SHALL send 7 bytes of 0x55 then 1 byte of 0xD5.
REQ-019 ETH_HEAD SHALL send 14 bytes:
- destination MAC: FF:FF:FF:FF:FF:FF for a request, latched MAC for a reply;
- BOARD_MAC;
- 0x08 0x06.
REQ-020 ARP_DATA SHALL send 46 bytes:
- 00 01 08 00 06 04;
- opcode 00 01 (request) or 00 02 (reply);
- BOARD_MAC, BOARD_IP;
- target MAC: all zero for a request, latched MAC for a reply;
- latched IP;
- 18 bytes of 0x00 padding.
REQ-021 All multi-byte fields SHALL be sent MSB byte first.
REQ-022 gmii_txd_valid SHALL stay high continuously for exactly 72 cycles per frame: 8 preamble, 60 data, 4 FCS.
REQ-023 CRC-32 generation SHALL use the reflected polynomial 0xEDB88320, initialised to 0xFFFFFFFF when the SFD is sent, and updated on each of the 60 header/payload bytes, bit 0 first.
REQ-024 FCS SHALL be the bitwise complement of the CRC register, sent as 4 bytes, least-significant byte first.
REQ-025 On the cycle after the last FCS byte, gmii_txd_valid SHALL be 0 and gmii_txd_data 0x00.
REQ-026 tx_done SHALL pulse for exactly one cycle on the cycle after the last FCS byte.
REQ-027 When gmii_txd_valid=0, gmii_txd_data SHALL be 0x00.
REQ-028 The byte counter SHALL be 6 bits wide and cleared at every state transition; no wrap-around occurs within a state.
REQ-029 Without ARP_TX_GAP_EN, the state SHALL return to IDLE on the tx_done cycle, and tx_busy falls in the same cycle; a start pulse in that cycle is accepted.

Reset
REQ-030 resetn low SHALL immediately force state IDLE, gmii_txd_valid=0, gmii_txd_data=0x00, tx_busy=0, tx_done=0, counter=0, CRC=0xFFFFFFFF and latched fields=0, including mid-frame, with the truncated frame abandoned.
REQ-031 After resetn is released, the first start request SHALL be accepted on the first clock edge.

Configuration
REQ-032 Macro ARP_TX_GAP_EN, when defined, SHALL insert state GAP after FCS:
- 12 idle cycles (interframe gap) with tx_busy=1;
- tx_done still pulses on the first GAP cycle;
- start requests during GAP are ignored.
REQ-033 When ARP_TX_GAP_EN is undefined, the GAP state and its counter logic SHALL be absent, and back-to-back frames are allowed with one idle cycle between them.

Verification
REQ-034 Reply: start with type=1, des_mac=0x001122AABBCC, des_ip=192.168.1.102 -> 72 valid bytes; dest MAC 00:11:22:AA:BB:CC; opcode 00 02; target IP C0 A8 01 66; single tx_done.
REQ-035 Request: start with type=0, des_mac=0, des_ip=0 -> dest MAC all 0xFF; opcode 00 01; target MAC all zero; target IP from DES_IP (C0 A8 01 66).
REQ-036 FCS: reference CRC model over the 60 data bytes matches the 4 transmitted FCS bytes; CRC over the 64 bytes gives residue 0xDEBB20E3.
REQ-037 Busy: a second start pulse at byte 30 -> ignored, frame content unchanged, exactly one tx_done.
REQ-038 Mid-frame reset: resetn low at byte 40 -> valid=0 in the same cycle; a new start after release produces a complete, correct 72-byte frame.
REQ-039 Gap (ARP_TX_GAP_EN defined): a start held continuously -> consecutive frames separated by exactly 12 idle cycles; without the macro, separated by 1 idle cycle.
